// File: rtl/demo_slave_responder.sv
// Single-beat bus responder: windowed address decode, programmable wait states,
// local byte memory, one-cycle completion pulse and a board-visible last-write byte.
module demo_slave_responder #(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    MEM_ADDR_WIDTH = 5,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 16'h8800,
    parameter int                    WAIT_STATES    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic                  s_rw_mode,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic                  s_rvalid,
    output logic                  s_err,
    output logic [DATA_WIDTH-1:0] demo_data,
    output logic [7:0]            wr_count
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]     demo_q, demo_d;
    logic                      err_q, err_d;
    logic [7:0]                wrc_q, wrc_d;

    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic                      rw_q;
    logic [DATA_WIDTH-1:0]     mem [0:(1<<MEM_ADDR_WIDTH)-1];

    logic                      latch_en;
    logic                      mem_we;
    logic                      hit;
    logic [MEM_ADDR_WIDTH-1:0] idx;

    // Decode works only on the latched request, never on the live bus inputs.
    assign hit = (addr_q[ADDR_WIDTH-1:MEM_ADDR_WIDTH] == BASE_ADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH]);
    assign idx = addr_q[MEM_ADDR_WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        demo_d   = demo_q;
        err_d    = err_q;
        wrc_d    = wrc_q;
        latch_en = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    latch_en = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                err_d   = ~hit;
                state_d = RESP;
                if (!rw_q) begin
                    rdata_d = hit ? mem[idx] : '1;
                end else if (hit) begin
                    mem_we = 1'b1;
                    demo_d = wdata_q;
                    wrc_d  = wrc_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            demo_q  <= '0;
            err_q   <= 1'b0;
            wrc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            demo_q  <= demo_d;
            err_q   <= err_d;
            wrc_q   <= wrc_d;
        end
    end

    // Request capture and memory are plain datapath storage with no reset.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            addr_q  <= s_addr;
            wdata_q <= s_wdata;
            rw_q    <= s_rw_mode;
        end
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    assign s_ready   = (state_q == IDLE);
    assign s_rvalid  = (state_q == RESP);
    assign s_err     = (state_q == RESP) & err_q;
    assign s_rdata   = rdata_q;
    assign demo_data = demo_q;
    assign wr_count  = wrc_q;

endmodule

// File: tb/tb_demo_slave_responder.sv
// Scoreboard bench for demo_slave_responder: transaction-level model feeds an
// expectation queue, a monitor pops on every completion pulse.
module tb_demo_slave_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_rw_mode = 1'b0;
    logic [15:0] s_addr = '0;
    logic [7:0]  s_wdata = '0;
    logic        s_ready, s_rvalid, s_err;
    logic [7:0]  s_rdata, demo_data, wr_count;

    logic        v0 = 1'b0;
    logic        rw0 = 1'b0;
    logic [15:0] a0 = '0;
    logic [7:0]  wd0 = '0;
    logic        ready0, rvalid0, err0;
    logic [7:0]  rdata0, demo0, wrc0;

    always #5 clk = ~clk;

    demo_slave_responder #(.WAIT_STATES(2)) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_rw_mode(s_rw_mode),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata),
        .s_rvalid(s_rvalid), .s_err(s_err), .demo_data(demo_data), .wr_count(wr_count)
    );

    demo_slave_responder #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .s_valid(v0), .s_rw_mode(rw0),
        .s_addr(a0), .s_wdata(wd0), .s_ready(ready0), .s_rdata(rdata0),
        .s_rvalid(rvalid0), .s_err(err0), .demo_data(demo0), .wr_count(wrc0)
    );

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic [7:0] demo;
        logic [7:0] wrc;
        int         acc;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;

    logic [7:0] mem_m [32];
    logic [7:0] m_rdata = '0;
    logic [7:0] m_demo = '0;
    logic [7:0] m_wrc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: no response within bound (t=%0t)", name, $time);
    endtask

    // Reference model: transaction-level effect of one accepted request.
    task automatic model_push(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                              input int acc);
        exp_t e;
        bit   hit;
        int   ix;
        hit = ((addr >> 5) == (16'h8800 >> 5));
        ix  = int'(addr % 32);
        if (!rw) begin
            m_rdata = hit ? mem_m[ix] : 8'hFF;
        end else if (hit) begin
            mem_m[ix] = wd;
            m_demo    = wd;
            m_wrc     = m_wrc + 8'd1;
        end
        e.rdata = m_rdata;
        e.err   = !hit;
        e.demo  = m_demo;
        e.wrc   = m_wrc;
        e.acc   = acc;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(output bit ok);
        int t = 0;
        @(negedge clk);
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        ok = s_ready;
        if (!ok) timeout("ready_wait");
    endtask

    task automatic issue(input logic rw, input logic [15:0] addr, input logic [7:0] wd);
        bit ok;
        wait_idle(ok);
        if (!ok) return;
        s_valid   = 1'b1;
        s_rw_mode = rw;
        s_addr    = addr;
        s_wdata   = wd;
        model_push(rw, addr, wd, cyc + 1);
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic issue0(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                          output int lat);
        int t = 0;
        int acc;
        lat = -1;
        @(negedge clk);
        while (!ready0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!ready0) begin
            timeout("ready0_wait");
            return;
        end
        v0 = 1'b1; rw0 = rw; a0 = addr; wd0 = wd;
        acc = cyc + 1;
        @(posedge clk);
        #1 v0 = 1'b0;
        t = 0;
        @(negedge clk);
        while (!rvalid0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!rvalid0) begin
            timeout("rvalid0_wait");
            return;
        end
        lat = cyc - acc;
    endtask

    // Monitor: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_rvalid) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rvalid: got rvalid=1 expected no response (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("rdata", 32'(s_rdata), 32'(e.rdata));
                    chk("err", 32'(s_err), 32'(e.err));
                    chk("demo_data", 32'(demo_data), 32'(e.demo));
                    chk("wr_count", 32'(wr_count), 32'(e.wrc));
                    chk("latency", 32'(cyc - e.acc), 32'd3);
                    chk("ready_in_resp", 32'(s_ready), 32'd0);
                end
            end else begin
                chk("err_unqualified", 32'(s_err), 32'd0);
            end
        end
    end

    initial begin
        bit ok;
        int since;
        int accepts;
        int lat;
        logic [7:0] last;

        // Power-on reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_rdata", 32'(s_rdata), 32'd0);
        chk("rst_demo", 32'(demo_data), 32'd0);
        chk("rst_wrc", 32'(wr_count), 32'd0);
        chk("rst_wrc0", 32'(wrc0), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) issue(1'b1, 16'h8800 + 16'(i), 8'(i * 7 + 3));

        // Directed scenarios: write/read-back, misses, index wrap
        issue(1'b1, 16'h8801, 8'hA5);
        issue(1'b0, 16'h8801, 8'h00);
        issue(1'b0, 16'h9001, 8'h00);
        issue(1'b1, 16'h9001, 8'h3C);
        issue(1'b1, 16'h881F, 8'h11);
        issue(1'b1, 16'h8800, 8'h22);
        issue(1'b0, 16'h881F, 8'h00);
        issue(1'b0, 16'h8800, 8'h00);

        // Reset in the middle of a WAIT: request must vanish
        wait_idle(ok);
        if (ok) begin
            s_valid = 1'b1; s_rw_mode = 1'b0; s_addr = 16'h8801;
            @(posedge clk);
            #1 s_valid = 1'b0;
            @(negedge clk);
            chk("in_wait_ready", 32'(s_ready), 32'd0);
            #2 rst = 1'b1;
            #1;
            chk("midrst_ready", 32'(s_ready), 32'd1);
            chk("midrst_rvalid", 32'(s_rvalid), 32'd0);
            chk("midrst_err", 32'(s_err), 32'd0);
            chk("midrst_rdata", 32'(s_rdata), 32'd0);
            chk("midrst_demo", 32'(demo_data), 32'd0);
            chk("midrst_wrc", 32'(wr_count), 32'd0);
            m_rdata = '0; m_demo = '0; m_wrc = '0;
            @(negedge clk);
            rst = 1'b0;
            repeat (6) @(negedge clk);
        end

        // Continuously held request: one accept per IDLE visit
        wait_idle(ok);
        if (ok) begin
            s_valid = 1'b1; s_rw_mode = 1'b0; s_addr = 16'h8803;
            since = -1;
            accepts = 0;
            for (int k = 0; k < 20; k++) begin
                if (since >= 0) since++;
                chk("ready_hold", 32'(s_ready), 32'(since < 0 || since == 5));
                if (s_ready) begin
                    model_push(1'b0, 16'h8803, 8'h00, cyc + 1);
                    accepts++;
                    since = 0;
                end
                if (k < 19) @(negedge clk);
            end
            @(posedge clk);
            #1 s_valid = 1'b0;
            chk("hold_accepts", 32'(accepts), 32'd4);
        end

        // Randomised traffic, mostly window hits
        for (int n = 0; n < 200; n++) begin
            logic [15:0] a;
            if ($urandom_range(0, 3) != 0) a = 16'h8800 | 16'($urandom_range(0, 31));
            else a = 16'($urandom);
            issue(1'($urandom), a, 8'($urandom));
        end

        // Zero-wait build: latency and counter wrap
        issue0(1'b0, 16'h8805, 8'h00, lat);
        chk("ws0_latency", 32'(lat), 32'd1);
        chk("ws0_err_hit", 32'(err0), 32'd0);
        issue0(1'b0, 16'h1234, 8'h00, lat);
        chk("ws0_miss_rdata", 32'(rdata0), 32'hFF);
        chk("ws0_miss_err", 32'(err0), 32'd1);
        last = '0;
        for (int i = 0; i < 257; i++) begin
            last = 8'($urandom);
            issue0(1'b1, 16'h8800 | 16'(i % 32), last, lat);
        end
        chk("ws0_wrc_wrap", 32'(wrc0), 32'd1);
        chk("ws0_demo", 32'(demo0), 32'(last));

        begin
            int t = 0;
            while (sb_q.size() != 0 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (sb_q.size() != 0) timeout("scoreboard_drain");
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
